// File: rtl/modexpa7_bus_sequencer.sv
// Bus master that walks a modexpa7_wrapper through parameter setup, precompute,
// operand-bank copy and exponentiation; host accesses pass straight through when idle.
module modexpa7_bus_sequencer #(
  parameter int OPERAND_ADDR_WIDTH = 7,
  parameter int POLL_GAP           = 4,
  parameter int TIMEOUT_CYCLES     = 1000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [OPERAND_ADDR_WIDTH+5:0] cmd_modulus_bits,
  input  logic [OPERAND_ADDR_WIDTH+5:0] cmd_exponent_bits,
  input  logic [31:0]                   cmd_mode,
  input  logic                          cmd_skip_init,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [1:0]                    err_code,
  input  logic                          host_cs,
  input  logic                          host_we,
  input  logic [OPERAND_ADDR_WIDTH+3:0] host_addr,
  input  logic [31:0]                   host_wr_data,
  output logic [31:0]                   host_rd_data,
  output logic                          host_blocked,
  output logic                          cs,
  output logic                          we,
  output logic [OPERAND_ADDR_WIDTH+3:0] address,
  output logic [31:0]                   write_data,
  input  logic [31:0]                   read_data
);
  localparam int AW = OPERAND_ADDR_WIDTH;
  localparam int LW = AW + 6;
  localparam int BW = AW + 4;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LW:0] MAX_BITS = (LW+1)'(32) << AW;

  localparam logic [4:0] ST_IDLE = 5'd0, ST_W_EBITS = 5'd1, ST_W_MBITS = 5'd2, ST_W_MODE = 5'd3;
  localparam logic [4:0] ST_CLR_INIT = 5'd4, ST_SET_INIT = 5'd5, ST_P_RD = 5'd6, ST_P_CAP = 5'd7;
  localparam logic [4:0] ST_P_GAP = 5'd8, ST_RD_C = 5'd9, ST_CAP_C = 5'd10, ST_WR_C = 5'd11;
  localparam logic [4:0] ST_RD_F = 5'd12, ST_CAP_F = 5'd13, ST_WR_F = 5'd14, ST_CLR_NEXT = 5'd15;
  localparam logic [4:0] ST_SET_NEXT = 5'd16, ST_TO_CLR = 5'd17, ST_ERR = 5'd18, ST_DONE = 5'd19;

  logic [4:0]    state_q, state_d;
  logic [LW-1:0] mbits_q, mbits_d, ebits_q, ebits_d;
  logic [31:0]   mode_q, mode_d, data_q, data_d;
  logic          skip_q, skip_d, poll_vld_q, poll_vld_d;
  logic [AW:0]   nw_q, nw_d, word_q, word_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          bus_cs_q, bus_cs_d, bus_we_q, bus_we_d;
  logic [BW-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic          idle, len_bad, status_bit, in_poll;

  function automatic logic [BW-1:0] reg_addr(input logic [7:0] r);
    return {1'b0, (AW+3)'(r)};
  endfunction

  function automatic logic [BW-1:0] bank_addr(input logic [2:0] b, input logic [AW:0] w);
    return {1'b1, b, w[AW-1:0]};
  endfunction

  assign idle       = (state_q == ST_IDLE);
  assign status_bit = poll_vld_q ? read_data[1] : read_data[0];
  assign in_poll    = (state_q == ST_P_RD) || (state_q == ST_P_CAP) || (state_q == ST_P_GAP);
  assign len_bad    = (cmd_modulus_bits == '0) || (cmd_exponent_bits == '0) ||
                      ({1'b0, cmd_modulus_bits} > MAX_BITS) || ({1'b0, cmd_exponent_bits} > MAX_BITS);

  always_comb begin
    state_d = state_q;  mbits_d = mbits_q;  ebits_d = ebits_q;  mode_d = mode_q;
    skip_d = skip_q;    nw_d = nw_q;        word_d = word_q;    data_d = data_q;
    gap_d = gap_q;      poll_vld_d = poll_vld_q;  err_code_d = err_code_q;
    tmo_d = in_poll ? tmo_q + TW'(1) : tmo_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        mbits_d = cmd_modulus_bits;  ebits_d = cmd_exponent_bits;
        mode_d  = cmd_mode;          skip_d  = cmd_skip_init;
        nw_d    = (AW+1)'(({1'b0, cmd_modulus_bits} + (LW+1)'(31)) >> 5);
        err_code_d = len_bad ? 2'b01 : 2'b00;
        state_d    = len_bad ? ST_ERR : ST_W_EBITS;
      end
      ST_W_EBITS:  state_d = ST_W_MBITS;
      ST_W_MBITS:  state_d = ST_W_MODE;
      ST_W_MODE:   state_d = skip_q ? ST_CLR_NEXT : ST_CLR_INIT;
      ST_CLR_INIT: state_d = ST_SET_INIT;
      ST_SET_INIT: begin state_d = ST_P_RD; tmo_d = '0; poll_vld_d = 1'b0; end
      ST_P_RD:     state_d = ST_P_CAP;
      ST_P_CAP: begin
        if (status_bit) begin
          state_d = poll_vld_q ? ST_DONE : ST_RD_C;
          word_d  = '0;
        end else if (POLL_GAP == 0) begin
          state_d = ST_P_RD;
        end else begin
          state_d = ST_P_GAP;
          gap_d   = '0;
        end
      end
      ST_P_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(POLL_GAP - 1)) state_d = ST_P_RD;
      end
      ST_RD_C:  state_d = ST_CAP_C;
      ST_CAP_C: begin data_d = read_data; state_d = ST_WR_C; end
      ST_WR_C:  state_d = ST_RD_F;
      ST_RD_F:  state_d = ST_CAP_F;
      ST_CAP_F: begin data_d = read_data; state_d = ST_WR_F; end
      // Terminal compare on nw-1 lets the full-depth bank finish without the counter wrapping.
      ST_WR_F: begin
        if (word_q == nw_q - (AW+1)'(1)) state_d = ST_CLR_NEXT;
        else begin word_d = word_q + (AW+1)'(1); state_d = ST_RD_C; end
      end
      ST_CLR_NEXT: state_d = ST_SET_NEXT;
      ST_SET_NEXT: begin state_d = ST_P_RD; tmo_d = '0; poll_vld_d = 1'b1; end
      ST_TO_CLR:   begin state_d = ST_ERR; err_code_d = 2'b10; end
      default:     state_d = ST_IDLE;
    endcase
    if (in_poll && !(state_q == ST_P_CAP && status_bit) && tmo_q >= TW'(TIMEOUT_CYCLES - 1))
      state_d = ST_TO_CLR;
  end

  // Bus registers are loaded from the next state so the access lines up with the state that owns it.
  always_comb begin
    bus_cs_d = 1'b0;  bus_we_d = 1'b0;  bus_addr_d = '0;  bus_wdata_d = '0;
    case (state_d)
      ST_W_EBITS:  begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_addr_d = reg_addr(8'h12); bus_wdata_d = 32'(ebits_d); end
      ST_W_MBITS:  begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_addr_d = reg_addr(8'h11); bus_wdata_d = 32'(mbits_d); end
      ST_W_MODE:   begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_addr_d = reg_addr(8'h10); bus_wdata_d = mode_d; end
      ST_CLR_INIT, ST_CLR_NEXT, ST_TO_CLR:
                   begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_addr_d = reg_addr(8'h08); end
      ST_SET_INIT: begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_addr_d = reg_addr(8'h08); bus_wdata_d = 32'd1; end
      ST_SET_NEXT: begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_addr_d = reg_addr(8'h08); bus_wdata_d = 32'd2; end
      ST_P_RD:     begin bus_cs_d = 1'b1; bus_addr_d = reg_addr(8'h09); end
      ST_RD_C:     begin bus_cs_d = 1'b1; bus_addr_d = bank_addr(3'b100, word_d); end
      ST_RD_F:     begin bus_cs_d = 1'b1; bus_addr_d = bank_addr(3'b110, word_d); end
      ST_WR_C:     begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_addr_d = bank_addr(3'b101, word_d); bus_wdata_d = data_d; end
      ST_WR_F:     begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_addr_d = bank_addr(3'b111, word_d); bus_wdata_d = data_d; end
      default:     bus_cs_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;  mbits_q <= '0;  ebits_q <= '0;  mode_q <= '0;
      skip_q <= 1'b0;      nw_q <= '0;     word_q <= '0;    data_q <= '0;
      gap_q <= '0;         tmo_q <= '0;    poll_vld_q <= 1'b0;  err_code_q <= '0;
      bus_cs_q <= 1'b0;    bus_we_q <= 1'b0;  bus_addr_q <= '0;  bus_wdata_q <= '0;
    end else begin
      state_q <= state_d;  mbits_q <= mbits_d;  ebits_q <= ebits_d;  mode_q <= mode_d;
      skip_q <= skip_d;    nw_q <= nw_d;        word_q <= word_d;    data_q <= data_d;
      gap_q <= gap_d;      tmo_q <= tmo_d;      poll_vld_q <= poll_vld_d;  err_code_q <= err_code_d;
      bus_cs_q <= bus_cs_d;  bus_we_q <= bus_we_d;  bus_addr_q <= bus_addr_d;  bus_wdata_q <= bus_wdata_d;
    end
  end

  assign cmd_ready    = idle;
  assign busy         = !idle;
  assign done         = (state_q == ST_DONE);
  assign error        = (state_q == ST_ERR);
  assign err_code     = err_code_q;
  assign host_blocked = !idle && host_cs;
  assign host_rd_data = idle ? read_data : 32'd0;
  assign cs           = idle ? host_cs : bus_cs_q;
  assign we           = idle ? host_we : bus_we_q;
  assign address      = idle ? host_addr : bus_addr_q;
  assign write_data   = idle ? host_wr_data : bus_wdata_q;
endmodule
